// File: rtl/focus_pkg.sv
// Shared constants, FSM state type and luma helper for the autofocus focus-metric path.
// Also imported by the VCM step controller.
package focus_pkg;

    localparam int unsigned DEF_WIN_X0 = 224;
    localparam int unsigned DEF_WIN_X1 = 415;
    localparam int unsigned DEF_WIN_Y0 = 144;
    localparam int unsigned DEF_WIN_Y1 = 335;
    localparam int unsigned DEF_THRESH = 8;
    localparam int unsigned DEF_ACC_W  = 32;

    // Wide enough for any column or line index of the supported timings.
    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {
        WAIT_VS,
        ACC,
        LATCH
    } focus_state_e;

    // Y = (R + 2G + B) >> 2, computed on a 10-bit sum.
    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/focus_luma_grad.sv
// Pixel front end: S1 capture, S2 luma, S3 cored horizontal gradient.
// A flush drops every stage so a frame boundary never leaks pixels into the next frame.
module focus_luma_grad
    import focus_pkg::*;
#(
    parameter int unsigned THRESH = DEF_THRESH
) (
    input  logic       VIDEO_CLK,
    input  logic       RESET_N,
    input  logic       flush_i,
    input  logic       pix_valid_i,
    input  logic       pix_first_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       grad_valid_o,
    output logic [7:0] grad_o
);

    localparam logic [8:0] Thr = 9'(THRESH);

    logic       s1_valid_q, s1_first_q;
    logic [7:0] s1_r_q, s1_g_q, s1_b_q;
    logic       s2_valid_q, s2_first_q;
    logic [7:0] s2_y_q, prev_y_q;
    logic       grad_valid_q;
    logic [7:0] grad_q;
    logic [7:0] abs_diff, cored;

    // The first window column has no predecessor, so its gradient is forced to zero.
    always_comb begin
        abs_diff = (s2_y_q >= prev_y_q) ? (s2_y_q - prev_y_q) : (prev_y_q - s2_y_q);
        cored    = abs_diff;
        if (s2_first_q || ({1'b0, abs_diff} < Thr)) begin
            cored = '0;
        end
    end

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N) begin
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_r_q       <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_y_q       <= '0;
            prev_y_q     <= '0;
            grad_valid_q <= 1'b0;
            grad_q       <= '0;
        end else begin
            s1_valid_q   <= pix_valid_i & ~flush_i;
            s1_first_q   <= pix_first_i;
            s1_r_q       <= r_i;
            s1_g_q       <= g_i;
            s1_b_q       <= b_i;
            s2_valid_q   <= s1_valid_q & ~flush_i;
            s2_first_q   <= s1_first_q;
            s2_y_q       <= luma(s1_r_q, s1_g_q, s1_b_q);
            if (s2_valid_q) begin
                prev_y_q <= s2_y_q;
            end
            grad_valid_q <= s2_valid_q & ~flush_i;
            grad_q       <= cored;
        end
    end

    assign grad_valid_o = grad_valid_q;
    assign grad_o       = grad_q;

endmodule

// File: rtl/focus_sharpness_acc.sv
// Per-frame focus metric: window counters, frame FSM, saturating gradient accumulator
// and the latched per-frame outputs handed to the VCM step controller.
module focus_sharpness_acc
    import focus_pkg::*;
#(
    parameter int unsigned WIN_X0 = DEF_WIN_X0,
    parameter int unsigned WIN_X1 = DEF_WIN_X1,
    parameter int unsigned WIN_Y0 = DEF_WIN_Y0,
    parameter int unsigned WIN_Y1 = DEF_WIN_Y1,
    parameter int unsigned THRESH = DEF_THRESH,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET_N,
    input  logic             VS,
    input  logic             HS,
    input  logic             DE,
    input  logic [7:0]       iR,
    input  logic [7:0]       iG,
    input  logic [7:0]       iB,
    output logic [ACC_W-1:0] FRAME_VAL,
    output logic [7:0]       FRAME_PEAK,
    output logic             FRAME_SAT,
    output logic             FRAME_RDY,
    output logic             ACC_BUSY
);

    localparam logic [CNT_W-1:0] X0 = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] X1 = CNT_W'(WIN_X1);
    localparam logic [CNT_W-1:0] Y0 = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] Y1 = CNT_W'(WIN_Y1);

    logic             vs_q, de_q;
    logic [CNT_W-1:0] x_q, y_q;
    focus_state_e     state_q, state_d;
    logic             vs_fall, in_win, pix_valid, pix_first;
    logic             grad_valid;
    logic [7:0]       grad;
    logic             acc_busy, latch_en;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   acc_sum;
    logic [7:0]       peak_q;
    logic             sat_q;
    logic             hs_unused;

    assign hs_unused = HS;

    assign vs_fall   = vs_q & ~VS;
    assign in_win    = (x_q >= X0) && (x_q <= X1) && (y_q >= Y0) && (y_q <= Y1);
    // Pixels are ignored until the first full frame starts; the edge cycle itself is dropped.
    assign pix_valid = DE & in_win & (state_q != WAIT_VS) & ~vs_fall;
    assign pix_first = (x_q == X0);

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N) begin
            vs_q <= 1'b1;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            vs_q <= VS;
            de_q <= DE;
            x_q  <= DE ? (x_q + CNT_W'(1)) : '0;
            if (vs_fall) begin
                y_q <= '0;
            end else if (de_q && !DE) begin
                y_q <= y_q + CNT_W'(1);
            end
        end
    end

    focus_luma_grad #(
        .THRESH(THRESH)
    ) u_luma_grad (
        .VIDEO_CLK   (VIDEO_CLK),
        .RESET_N     (RESET_N),
        .flush_i     (vs_fall),
        .pix_valid_i (pix_valid),
        .pix_first_i (pix_first),
        .r_i         (iR),
        .g_i         (iG),
        .b_i         (iB),
        .grad_valid_o(grad_valid),
        .grad_o      (grad)
    );

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N) begin
            state_q <= WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_VS: if (vs_fall) state_d = ACC;
            ACC:     if (vs_fall) state_d = LATCH;
            LATCH:   state_d = ACC;
            default: state_d = WAIT_VS;
        endcase
    end

    always_comb begin
        acc_busy = 1'b0;
        latch_en = 1'b0;
        unique case (state_q)
            ACC:     acc_busy = 1'b1;
            LATCH:   latch_en = 1'b1;
            default: ;
        endcase
    end

    assign acc_sum = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, grad};

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N || latch_en) begin
            acc_q  <= '0;
            peak_q <= '0;
            sat_q  <= 1'b0;
        end else if (acc_busy && grad_valid && !vs_fall) begin
            if (acc_sum[ACC_W]) begin
                acc_q <= '1;
                sat_q <= 1'b1;
            end else begin
                acc_q <= acc_sum[ACC_W-1:0];
            end
            if (grad > peak_q) begin
                peak_q <= grad;
            end
        end
    end

    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET_N) begin
            FRAME_VAL  <= '0;
            FRAME_PEAK <= '0;
            FRAME_SAT  <= 1'b0;
            FRAME_RDY  <= 1'b0;
        end else begin
            FRAME_RDY <= latch_en;
            if (latch_en) begin
                FRAME_VAL  <= acc_q;
                FRAME_PEAK <= peak_q;
                FRAME_SAT  <= sat_q;
            end
        end
    end

    assign ACC_BUSY = acc_busy;

endmodule

// File: tb/tb_focus_sharpness_acc.sv
// Directed frames on a reduced raster; a frame-level model predicts each report and the
// compare process checks both a 32-bit and a 16-bit accumulator instance on every cycle.
module tb_focus_sharpness_acc;

    localparam int COLS = 40;
    localparam int ROWS = 24;
    localparam int WX0  = 8;
    localparam int WX1  = 31;
    localparam int WY0  = 4;
    localparam int WY1  = 19;
    localparam int THR  = 8;

    typedef struct {
        int pat;
        int px;
        int py;
        int rst_line;
        bit lit_en;
        int v32;
        int pk;
        int v16;
        int s16;
    } frame_t;

    logic        clk = 1'b0;
    logic        RESET_N, VS, HS, DE;
    logic [7:0]  r, g, b;
    logic [31:0] val32;
    logic [15:0] val16;
    logic [7:0]  peak32, peak16;
    logic        sat32, sat16, rdy32, rdy16, busy32, busy16;

    logic [7:0]  img_r [0:ROWS-1][0:COLS-1];
    logic [7:0]  img_g [0:ROWS-1][0:COLS-1];
    logic [7:0]  img_b [0:ROWS-1][0:COLS-1];

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc = 0;
    int drop_n = -100;
    bit drop_armed = 1'b0;
    bit started = 1'b0;

    // Prediction for the frame most recently driven; adopted when its report is due.
    logic [31:0] pend_v32;
    logic [15:0] pend_v16;
    logic [7:0]  pend_pk;
    logic        pend_s32, pend_s16;
    bit          pend_lit_en;
    int          pend_lit_v32, pend_lit_pk, pend_lit_v16, pend_lit_s16;

    frame_t frames[$];

    initial forever #5 clk = ~clk;

    focus_sharpness_acc #(
        .WIN_X0(WX0), .WIN_X1(WX1), .WIN_Y0(WY0), .WIN_Y1(WY1), .THRESH(THR), .ACC_W(32)
    ) dut (
        .VIDEO_CLK(clk), .RESET_N(RESET_N), .VS(VS), .HS(HS), .DE(DE),
        .iR(r), .iG(g), .iB(b),
        .FRAME_VAL(val32), .FRAME_PEAK(peak32), .FRAME_SAT(sat32), .FRAME_RDY(rdy32),
        .ACC_BUSY(busy32)
    );

    focus_sharpness_acc #(
        .WIN_X0(WX0), .WIN_X1(WX1), .WIN_Y0(WY0), .WIN_Y1(WY1), .THRESH(THR), .ACC_W(16)
    ) dut16 (
        .VIDEO_CLK(clk), .RESET_N(RESET_N), .VS(VS), .HS(HS), .DE(DE),
        .iR(r), .iG(g), .iB(b),
        .FRAME_VAL(val16), .FRAME_PEAK(peak16), .FRAME_SAT(sat16), .FRAME_RDY(rdy16),
        .ACC_BUSY(busy16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, ncyc, act, exp);
        end
    endtask

    function automatic int luma_of(input int y, input int x);
        return (int'(img_r[y][x]) + 2 * int'(img_g[y][x]) + int'(img_b[y][x])) / 4;
    endfunction

    function automatic void model_frame(output longint sum, output int peak);
        int gr;
        sum  = 0;
        peak = 0;
        for (int y = WY0; y <= WY1; y++) begin
            for (int x = WX0 + 1; x <= WX1; x++) begin
                gr = luma_of(y, x) - luma_of(y, x - 1);
                if (gr < 0) gr = -gr;
                if (gr < THR) gr = 0;
                sum += gr;
                if (gr > peak) peak = gr;
            end
        end
    endfunction

    task automatic build_image(input int pat, input int px, input int py);
        int v;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                case (pat)
                    0:       v = 128;
                    1:       v = (x % 2 == 1) ? 255 : 0;
                    2:       v = x * 4;
                    3:       v = x * 8;
                    4:       v = (x == px && y == py) ? 255 : 0;
                    default: v = 0;
                endcase
                if (pat == 5) begin
                    img_r[y][x] = 8'((x * 37 + y * 11) % 256);
                    img_g[y][x] = 8'((x * x * 3 + y) % 256);
                    img_b[y][x] = 8'((1024 + 255 - x * 13) % 256);
                end else begin
                    img_r[y][x] = 8'(v % 256);
                    img_g[y][x] = 8'(v % 256);
                    img_b[y][x] = 8'(v % 256);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        step();
        VS         = 1'b0;
        drop_armed = started;
        drop_n     = ncyc;
        started    = 1'b1;
        repeat (7) step();
        step();
        VS = 1'b1;
        repeat (39) step();
    endtask

    task automatic drive_frame(input frame_t f);
        longint sum;
        int     pk;
        build_image(f.pat, f.px, f.py);
        frame_start();
        for (int y = 0; y < ROWS; y++) begin
            if (y == f.rst_line) begin
                step();
                RESET_N = 1'b0;
                repeat (3) step();
                RESET_N = 1'b1;
                started = 1'b0;
            end
            for (int x = 0; x < COLS; x++) begin
                step();
                DE = 1'b1;
                r  = img_r[y][x];
                g  = img_g[y][x];
                b  = img_b[y][x];
            end
            for (int i = 0; i < 8; i++) begin
                step();
                DE = 1'b0;
                HS = (i >= 4);
            end
        end
        repeat (10) step();
        model_frame(sum, pk);
        pend_v32     = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sum);
        pend_s32     = (sum > 64'hFFFF_FFFF);
        pend_v16     = (sum > 65535) ? 16'hFFFF : 16'(sum);
        pend_s16     = (sum > 65535);
        pend_pk      = 8'(pk);
        pend_lit_en  = f.lit_en;
        pend_lit_v32 = f.v32;
        pend_lit_pk  = f.pk;
        pend_lit_v16 = f.v16;
        pend_lit_s16 = f.s16;
    endtask

    task automatic add(input int pat, input int px, input int py, input int rst_line,
                       input bit lit_en, input int v32, input int pk, input int v16,
                       input int s16);
        frame_t f;
        f = '{pat, px, py, rst_line, lit_en, v32, pk, v16, s16};
        frames.push_back(f);
    endtask

    // Compare process: expected outputs follow from reset, VS drop times and model reports.
    initial begin
        logic [31:0] h_v32;
        logic [15:0] h_v16;
        logic [7:0]  h_pk;
        logic        h_s32, h_s16, exp_rdy, exp_busy, rst_prev;
        bit          running;
        h_v32 = '0; h_v16 = '0; h_pk = '0; h_s32 = 1'b0; h_s16 = 1'b0;
        running  = 1'b0;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            exp_rdy = 1'b0;
            if (!rst_prev) begin
                h_v32 = '0; h_v16 = '0; h_pk = '0; h_s32 = 1'b0; h_s16 = 1'b0;
                running = 1'b0;
            end else begin
                if (ncyc == drop_n + 2) running = 1'b1;
                if (drop_armed && ncyc == drop_n + 3) begin
                    exp_rdy = 1'b1;
                    h_v32 = pend_v32; h_v16 = pend_v16; h_pk = pend_pk;
                    h_s32 = pend_s32; h_s16 = pend_s16;
                    if (pend_lit_en) begin
                        check("lit_val32", val32, pend_lit_v32);
                        check("lit_peak", peak32, pend_lit_pk);
                        check("lit_val16", val16, pend_lit_v16);
                        check("lit_sat16", sat16, pend_lit_s16);
                    end
                end
            end
            exp_busy = running && !(drop_armed && ncyc == drop_n + 2);
            check("rdy32", rdy32, exp_rdy);
            check("busy32", busy32, exp_busy);
            check("val32", val32, h_v32);
            check("peak32", peak32, h_pk);
            check("sat32", sat32, h_s32);
            check("rdy16", rdy16, exp_rdy);
            check("busy16", busy16, exp_busy);
            check("val16", val16, h_v16);
            check("peak16", peak16, h_pk);
            check("sat16", sat16, h_s16);
            rst_prev = RESET_N;
        end
    end

    initial begin
        RESET_N = 1'b0;
        VS = 1'b1;
        HS = 1'b1;
        DE = 1'b0;
        r = '0;
        g = '0;
        b = '0;
        pend_v32 = '0; pend_v16 = '0; pend_pk = '0; pend_s32 = 1'b0; pend_s16 = 1'b0;
        pend_lit_en = 1'b0;
        pend_lit_v32 = 0; pend_lit_pk = 0; pend_lit_v16 = 0; pend_lit_s16 = 0;
        repeat (4) step();
        RESET_N = 1'b1;
        repeat (20) step();

        //   pat px  py  rst lit  v32    pk   v16    s16
        add(0, 0,  0,  -1, 1'b0, 0,     0,   0,     0);  // first frame after reset: no report
        add(1, 0,  0,  -1, 1'b1, 93840, 255, 65535, 1);
        add(0, 0,  0,  -1, 1'b1, 0,     0,   0,     0);
        add(2, 0,  0,  -1, 1'b1, 0,     0,   0,     0);
        add(3, 0,  0,  -1, 1'b1, 2944,  8,   2944,  0);
        add(4, 2,  2,  -1, 1'b1, 0,     0,   0,     0);
        add(4, 20, 10, -1, 1'b1, 510,   255, 510,   0);
        add(4, 8,  10, -1, 1'b1, 255,   255, 255,   0);
        add(4, 7,  10, -1, 1'b1, 0,     0,   0,     0);
        add(4, 31, 10, -1, 1'b1, 255,   255, 255,   0);
        add(4, 20, 3,  -1, 1'b1, 0,     0,   0,     0);
        add(4, 20, 19, -1, 1'b1, 510,   255, 510,   0);
        add(5, 0,  0,  -1, 1'b0, 0,     0,   0,     0);
        add(1, 0,  0,  10, 1'b0, 0,     0,   0,     0);  // reset mid-frame: never reported
        add(3, 0,  0,  -1, 1'b0, 0,     0,   0,     0);  // starts after reset: no report
        add(3, 0,  0,  -1, 1'b1, 2944,  8,   2944,  0);
        add(0, 0,  0,  -1, 1'b1, 0,     0,   0,     0);

        foreach (frames[i]) drive_frame(frames[i]);
        frame_start();
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/focus_sharpness_acc.md
# focus_sharpness_acc

Per-frame focus-metric accumulator feeding the autofocus VCM step controller. It consumes the normalized (negative-pulse) sync and RGB pixel stream from the sync-modify stage. For each frame it computes cored horizontal-gradient energy and the peak gradient inside a fixed centre window. At every frame end it hands one sharpness sample per frame to the step controller, which uses it for its hill-climb.

## Interface
- `WIN_X0`, default 224: first active pixel column inside the window.
- `WIN_X1`, default 415: last column inside the window, inclusive.
- `WIN_Y0`, default 144: first active line inside the window.
- `WIN_Y1`, default 335: last line inside the window, inclusive.
- `THRESH`, default 8: coring threshold. Gradients below it count as 0.
- `ACC_W`, default 32: accumulator and `FRAME_VAL` width.
- `VIDEO_CLK` in 1: pixel clock. Single clock domain.
- `RESET_N` in 1: reset, synchronous, active-low.
- `VS` in 1: vertical sync, active-low pulse.
- `HS` in 1: horizontal sync, active-low pulse. Not used for counting; kept for interface symmetry.
- `DE` in 1: active-pixel qualifier.
- `iR`, `iG`, `iB` in 8 each: pixel colour components.
- `FRAME_VAL` out `ACC_W`: latched gradient energy of the last complete frame.
- `FRAME_PEAK` out 8: maximum cored gradient of the last complete frame.
- `FRAME_SAT` out 1: the accumulator saturated during the last frame.
- `FRAME_RDY` out 1: one-cycle pulse when the three `FRAME_*` outputs update.
- `ACC_BUSY` out 1: high while in the ACC state.

## Operation
- **Luma:** Y = (R + 2G + B) >> 2. The sum is 10 bits wide; truncate the result to 8 bits.
- **Counters:**
  - x counts DE-high pixels and clears while DE is low.
  - y clears on the VS falling edge and increments on each DE falling edge.
  - The window test uses the pre-increment x and y.
- **Gradient:** G = |Y(x) − Y(x−1)|.
  - The pixel at x = `WIN_X0` has no predecessor, so its G = 0.
  - Any G < `THRESH` becomes 0.
- **Accumulation** (in-window pixels only):
  - acc += G, saturating at 2^`ACC_W`−1. When saturation occurs, set the sat flag.
  - peak = max(peak, G).
- **States:**
  - **WAIT_VS:** entered on reset. Ignore pixels. On a VS falling edge, go to ACC. The partial frame after reset is never reported.
  - **ACC:** accumulate. On a VS falling edge, go to LATCH.
  - **LATCH:** one cycle.
    - `FRAME_VAL` ← acc, `FRAME_PEAK` ← peak, `FRAME_SAT` ← sat.
    - `FRAME_RDY` = 1.
    - Clear acc, peak and sat. Return to ACC.
- **VS edge detection:** compare against a one-cycle registered copy of VS.
- **VS falling edge while DE is high (malformed timing):** same LATCH behaviour. Pipeline contents in flight at that moment are discarded.
- **Window never reached** (e.g. a short frame): report `FRAME_VAL` = 0 and `FRAME_PEAK` = 0.

## Timing
- **Reset values:** all outputs 0, state WAIT_VS, counters 0. The VS edge register is set to 1.
- **Pipeline:** 4 stages.
  - S1: register pixel, DE and the in-window flag.
  - S2: luma.
  - S3: abs-diff and coring.
  - S4: accumulate.
  - A pixel affects acc 4 cycles after it is sampled.
- **Blanking requirement:** at least 4 cycles of DE low before the VS falling edge. The pipeline is then flushed before LATCH.
- **Latch timing:**
  - LATCH occurs in the cycle after the edge is registered.
  - `FRAME_RDY` is high exactly 1 cycle, 2 cycles after VS is first sampled low.
  - `FRAME_*` values hold until the next `FRAME_RDY`.
- **Reset deasserted mid-frame:** no `FRAME_RDY` until the second VS falling edge.

## Structure
- **Shared package `focus_pkg`:**
  - Default window constants, `THRESH` and `ACC_W`.
  - A luma function.
  - The state enum {WAIT_VS, ACC, LATCH}.
  - The package is reused by the step controller.
- **Sub-module `focus_luma_grad`:** stages S1–S3, producing the cored gradient plus a valid bit.
- **Top level:** counters, FSM, the S4 accumulator and the output registers.

## Test plan
- **Flat grey frame (all pixels 0x80), 640×480 timing:** after frame 2, `FRAME_RDY` pulses once per frame with `FRAME_VAL` = 0, `FRAME_PEAK` = 0, `FRAME_SAT` = 0.
- **Alternating grey columns 0x00/0xFF:** `FRAME_VAL` = 255×191×192 = 9 351 360 and `FRAME_PEAK` = 255.
- **Horizontal grey ramps, coring check:**
  - Ramp of +4 per pixel: `FRAME_VAL` = 0.
  - Ramp of +8 per pixel: `FRAME_VAL` = 8×191×192 = 293 376 and `FRAME_PEAK` = 8.
- **`ACC_W` = 16 with the column pattern:** `FRAME_VAL` = 65535 and `FRAME_SAT` = 1. The next flat frame reports 0 with `FRAME_SAT` = 0.
- **Single bright pixel at (100,100), outside the window:** `FRAME_VAL` = 0. The same pixel at (300,200), inside the window, gives `FRAME_VAL` = 2×255 = 510 and `FRAME_PEAK` = 255.
- **`RESET_N` low for 3 cycles mid-frame:** all outputs read 0. The first frame after reset produces no `FRAME_RDY`. The next full frame reports the correct value.
